// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states,
// and the big-endian lane helpers used for load extraction and store merging.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } lsu_state_t;

  // Right-shift that brings the addressed lane down to bit 0. Lanes are
  // big-endian, so byte offset 0 lives in the top byte of the word.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [4:0] sh;
    sh = 5'd0;
    case (size)
      SZ_BYTE: sh = {~offset, 3'b000};
      SZ_HALF: sh = offset[1] ? 5'd0 : 5'd16;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // Pull the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> lane_shift(size, offset);
    case (size)
      SZ_BYTE: result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      SZ_HALF: result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replace only the addressed lane of the read word with the new data; the
  // remaining bytes are written back exactly as they were read.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = lane_shift(size, offset);
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << sh;
      SZ_HALF: mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (word & ~mask) | ((data << sh) & mask);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extract+extend for loads, lane merge for
// sub-word stores. Fed with the word captured from memory in CAP.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] load_word,
  output logic [31:0] merge_word
);

  // Both results are always computed; the FSM picks the one it needs.
  always_comb begin
    load_word  = lane_extract(rd_word, size, offset, is_unsigned);
    merge_word = lane_merge(rd_word, store_data, size, offset);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences one load/store at a time into a
// word-wide synchronous memory, with sub-word loads and read-modify-write
// sub-word stores. Faulting requests respond without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqStoreData,
  output logic        respValid,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        outOfRange,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  lsu_state_t  state, next_state;

  logic        op_write;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [1:0]  op_offset;
  logic [31:0] op_store_data;
  logic        mis_flag;
  logic        oor_flag;

  logic [31:0] word_base;
  logic        req_mis;
  logic        req_oor;
  logic        req_fault;
  logic        word_store;
  logic        accept;
  logic [31:0] load_word;
  logic [31:0] merge_word;

  assign word_base  = {reqAddress[31:2], 2'b00};
  assign req_mis    = (reqSize == 2'b11) ||
                      ((reqSize == SZ_HALF) && reqAddress[0]) ||
                      ((reqSize == SZ_WORD) && (reqAddress[1:0] != 2'b00));
  // 33-bit sum so a base near 2^32 cannot wrap back into range.
  assign req_oor    = ({1'b0, word_base} + 33'd3) >= 33'(MEM_BYTES);
  assign req_fault  = req_mis || req_oor;
  assign word_store = reqWrite && (reqSize == SZ_WORD);
  assign accept     = reqValid && (state == IDLE);

  assign misaligned = mis_flag;
  assign outOfRange = oor_flag;

  lsu_lane_align u_align (
    .rd_word     (memReadData),
    .store_data  (op_store_data),
    .size        (op_size),
    .offset      (op_offset),
    .is_unsigned (op_unsigned),
    .load_word   (load_word),
    .merge_word  (merge_word)
  );

  // State register; reset returns to IDLE immediately, dropping any strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; strobes and handshake are pure decodes of the state
  // register, so each is high for exactly the one cycle spent in its state.
  always_comb begin
    next_state = state;
    reqReady   = 1'b0;
    respValid  = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (req_fault)       next_state = RESP;
          else if (word_store) next_state = WR;
          else                 next_state = RD;
        end
      end
      RD: begin
        memRead    = 1'b1;
        next_state = CAP;
      end
      CAP:     next_state = op_write ? WR : RESP;
      WR: begin
        memWrite   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        respValid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latching, fault flags and the address/data/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write      <= 1'b0;
      op_size       <= SZ_BYTE;
      op_unsigned   <= 1'b0;
      op_offset     <= 2'b00;
      op_store_data <= 32'h0;
      mis_flag      <= 1'b0;
      oor_flag      <= 1'b0;
      loadData      <= 32'h0;
      memAddress    <= 32'h0;
      memWriteData  <= 32'h0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_write      <= reqWrite;
          op_size       <= reqSize;
          op_unsigned   <= reqUnsigned;
          op_offset     <= reqAddress[1:0];
          op_store_data <= reqStoreData;
          mis_flag      <= req_mis;
          oor_flag      <= req_oor && !req_mis;
          loadData      <= 32'h0;
          if (!req_fault) memAddress <= word_base;
          if (!req_fault && word_store) memWriteData <= reqStoreData;
        end
        CAP: begin
          if (op_write) memWriteData <= merge_word;
          else          loadData     <= load_word;
        end
        RESP: begin
          mis_flag <= 1'b0;
          oor_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array memory behind the DUT plus a
// separate byte-addressed reference model of what each request must do.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqUnsigned = 1'b0;
  logic [31:0] reqAddress = 32'h0;
  logic [31:0] reqStoreData = 32'h0;
  logic        respValid;
  logic [31:0] loadData;
  logic        misaligned;
  logic        outOfRange;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData = 32'h0;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [9:0]  ma;

  int vectors    = 0;
  int miscompares = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqSize      (reqSize),
    .reqUnsigned  (reqUnsigned),
    .reqAddress   (reqAddress),
    .reqStoreData (reqStoreData),
    .respValid    (respValid),
    .loadData     (loadData),
    .misaligned   (misaligned),
    .outOfRange   (outOfRange),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  always #5 clk = ~clk;

  assign ma = memAddress[9:0];

  // Big-endian synchronous word memory over a byte array.
  always @(posedge clk) begin
    if (memWrite) begin
      mem[ma]         <= memWriteData[31:24];
      mem[ma + 10'd1] <= memWriteData[23:16];
      mem[ma + 10'd2] <= memWriteData[15:8];
      mem[ma + 10'd3] <= memWriteData[7:0];
    end
    if (memRead)
      memReadData <= {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_ready"}, 32'(reqReady), 32'd1);
    chk({pfx, "_resp"},  32'(respValid), 32'd0);
    chk({pfx, "_strb"},  {30'd0, memRead, memWrite}, 32'd0);
    chk({pfx, "_flags"}, {30'd0, misaligned, outOfRange}, 32'd0);
    chk({pfx, "_load"},  loadData, 32'h0);
    chk({pfx, "_addr"},  memAddress, 32'h0);
    chk({pfx, "_wdata"}, memWriteData, 32'h0);
  endtask

  // One request, checked cycle by cycle against the reference model.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] obs_ld);
    longint   ai;
    longint   v;
    logic     e_mis, e_oor;
    int       e_lat, e_rd, e_wr;
    logic [31:0] e_ld;
    int       lat, rd_cnt, wr_cnt, both, resp_cnt;
    logic [31:0] ld;
    logic     m, o;

    ai    = longint'(a);
    e_mis = (sz == 2'd3) || (sz == 2'd1 && (ai % 2) != 0) || (sz == 2'd2 && (ai % 4) != 0);
    e_oor = !e_mis && ((ai - (ai % 4)) + 3 >= MEM_BYTES);
    e_ld  = 32'h0;
    if (e_mis || e_oor) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!w) begin
      e_lat = 3; e_rd = 1; e_wr = 0;
      if (sz == 2'd0) begin
        v = ref_mem[ai];
        if (!u && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
        v = ref_mem[ai] * 256 + ref_mem[ai+1];
        if (!u && v >= 32768) v = v - 65536;
      end else begin
        v = ref_word(int'(ai));
      end
      e_ld = v[31:0];
    end else if (sz == 2'd2) begin
      e_lat = 2; e_rd = 0; e_wr = 1;
    end else begin
      e_lat = 4; e_rd = 1; e_wr = 1;
    end

    @(negedge clk);
    chk("ready_before", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u;
    reqAddress = a; reqStoreData = d;
    @(posedge clk);
    #1 reqValid = 1'b0;

    lat = 0; rd_cnt = 0; wr_cnt = 0; both = 0; resp_cnt = 0;
    ld = 32'h0; m = 1'b0; o = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (memRead) rd_cnt++;
      if (memWrite) wr_cnt++;
      if (memRead && memWrite) both++;
      if (respValid) begin
        resp_cnt++;
        if (lat == 0) begin
          lat = i; ld = loadData; m = misaligned; o = outOfRange;
        end
      end
    end
    chk("latency",   32'(lat), 32'(e_lat));
    chk("resp_once", 32'(resp_cnt), 32'd1);
    chk("load_data", ld, e_ld);
    chk("misalign",  32'(m), 32'(e_mis));
    chk("out_range", 32'(o), 32'(e_oor));
    chk("rd_strobes", 32'(rd_cnt), 32'(e_rd));
    chk("wr_strobes", 32'(wr_cnt), 32'(e_wr));
    chk("rd_wr_overlap", 32'(both), 32'd0);
    chk("ready_after", 32'(reqReady), 32'd1);

    if (w && !e_mis && !e_oor) begin
      if (sz == 2'd0) ref_mem[ai] = d[7:0];
      else if (sz == 2'd1) begin
        ref_mem[ai] = d[15:8]; ref_mem[ai+1] = d[7:0];
      end else begin
        ref_mem[ai] = d[31:24]; ref_mem[ai+1] = d[23:16];
        ref_mem[ai+2] = d[15:8]; ref_mem[ai+3] = d[7:0];
      end
    end
    obs_ld = ld;
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          accepts, resp_k, wr_seen;

    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end

    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_held");
    rst_n = 1'b1;

    // Word store then word load.
    do_req(1'b1, 2'd2, 1'b0, 32'd0, 32'h0777_DFF0, r);
    chk("t1_b0", 32'(mem[0]), 32'h07);
    chk("t1_b1", 32'(mem[1]), 32'h77);
    chk("t1_b2", 32'(mem[2]), 32'hDF);
    chk("t1_b3", 32'(mem[3]), 32'hF0);
    do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, r);
    chk("t1_lw", r, 32'h0777_DFF0);

    // Signed vs unsigned sub-word loads.
    do_req(1'b1, 2'd2, 1'b0, 32'd4, 32'h12FF_3456, r);
    do_req(1'b0, 2'd0, 1'b0, 32'd5, 32'h0, r);
    chk("t2_lb", r, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'd5, 32'h0, r);
    chk("t2_lbu", r, 32'h0000_00FF);
    do_req(1'b0, 2'd1, 1'b1, 32'd6, 32'h0, r);
    chk("t2_lhu", r, 32'h0000_3456);
    do_req(1'b0, 2'd1, 1'b0, 32'd4, 32'h0, r);
    chk("t2_lh0", r, 32'h0000_12FF);

    // Byte store read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'd8, 32'hAABB_CCDD, r);
    do_req(1'b1, 2'd0, 1'b0, 32'd10, 32'hFFFF_FF11, r);
    chk("t3_word", mem_word(8), 32'hAABB_11DD);
    do_req(1'b1, 2'd1, 1'b0, 32'd8, 32'h0000_9876, r);
    chk("t3_half", mem_word(8), 32'h9876_11DD);

    // Faults, including the last in-range and first out-of-range words.
    do_req(1'b0, 2'd1, 1'b0, 32'd3, 32'h0, r);
    do_req(1'b0, 2'd2, 1'b0, 32'd1000, 32'h0, r);
    do_req(1'b1, 2'd2, 1'b0, 32'd996, 32'h1357_9BDF, r);
    do_req(1'b1, 2'd3, 1'b0, 32'd12, 32'h1, r);
    do_req(1'b1, 2'd0, 1'b0, 32'd1001, 32'h1, r);
    do_req(1'b0, 2'd1, 1'b0, 32'd998, 32'h0, r);

    // Busy: reqValid held through a byte store.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqUnsigned = 1'b0;
    reqAddress = 32'd21; reqStoreData = 32'h0000_005A;
    accepts = 0; resp_k = -1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (reqReady && reqValid) accepts++;
      if (respValid) resp_k = k;
    end
    @(negedge clk);
    chk("t5_ready_again", 32'(reqReady), 32'd1);
    reqValid = 1'b0;
    chk("t5_accepts", 32'(accepts), 32'd1);
    chk("t5_resp_cycle", 32'(resp_k), 32'd4);
    ref_mem[21] = 8'h5A;
    chk("t5_byte", 32'(mem[21]), 32'h5A);

    // Async reset in CAP of a byte store.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0;
    reqAddress = 32'd41; reqStoreData = 32'h0000_00C3;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("t6");
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (memWrite) wr_seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (memWrite) wr_seen++;
    end
    chk("t6_no_write", 32'(wr_seen), 32'd0);
    chk("t6_word", mem_word(40), ref_word(40));

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 1010)), $urandom, r);
    end

    for (int i = 0; i < 250; i++)
      chk("mem_image", mem_word(i * 4), ref_word(i * 4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
